uart_block_bridge: RTL
======================

# uart_block_bridge

Parametrised byte/block bridge between a byte-wide AXI-Stream source/sink (UART) and a block-wide AXI-Stream cipher core. It replaces the fixed 8->96 / 96->8 FIFO adapter pair with one block that has:
- configurable block size and byte order;
- idle-timeout and explicit-flush padding of partial blocks;
- a pad count carried with each block, so the return path drops padding bytes.

## Interface
Parameters:
- BLOCK_BYTES, 12, bytes per block (>=2); block width BW = 8*BLOCK_BYTES
- MSB_FIRST, 1, 1: first stream byte occupies bits [BW-1:BW-8]; 0: first byte occupies bits [7:0]
- TIMEOUT, 0, idle cycles before a partial block is padded; 0 disables the timeout
- PAD_BYTE, 8'h00, fill value for padded lanes
- PW, $clog2(BLOCK_BYTES+1), pad count width (derived)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  force-close the current partial block
- s_byte_tdata/tvalid/tready  in/in/out  8/1/1  byte input (from UART RX)
- m_blk_tdata/tvalid/tready  out/out/in  BW/1/1  gathered block (to cipher)
- m_blk_tuser  out  PW  number of padded lanes in m_blk_tdata
- s_blk_tdata/tvalid/tready  in/in/out  BW/1/1  block input (from cipher)
- s_blk_tuser  in  PW  pad count for the returning block
- m_byte_tdata/tvalid/tready  out/out/in  8/1/1  byte output (to UART TX)

## Operation
Gather path, states FILL and HOLD:
- Lane index idx runs 0..BLOCK_BYTES-1. s_byte_tready = (state==FILL).
- An accepted byte writes lane idx, ordered per MSB_FIRST, then idx increments.
- Accepting the byte at idx==BLOCK_BYTES-1 enters HOLD with m_blk_tuser=0.
- Close condition: in FILL with idx>0, either flush is high or the idle counter expires. On close:
  - all lanes idx..BLOCK_BYTES-1 are filled with PAD_BYTE;
  - m_blk_tuser = BLOCK_BYTES-idx;
  - the state moves to HOLD.
- Flush with idx==0 is ignored. Flush and the timeout have no effect in HOLD.
- Flush in the same cycle as a byte accept: the byte is written first, then padding is applied. If that byte completes the block, pad=0.
- HOLD: m_blk_tvalid=1, data/tuser held stable. On m_blk_tready, return to FILL with idx=0.
- Idle counter:
  - increments each FILL cycle with idx>0 and no accept;
  - clears on any accept and on leaving FILL;
  - expires when it would reach TIMEOUT.

Scatter path, states IDLE and SEND:
- s_blk_tready = (state==IDLE).
- On accept, the block is loaded into a shift register and count = BLOCK_BYTES - s_blk_tuser.
- If s_blk_tuser >= BLOCK_BYTES, the block is discarded: stay in IDLE, emit nothing.
- SEND: m_byte_tvalid=1, m_byte_tdata = first-order lane (per MSB_FIRST).
- On m_byte_tready: shift one lane and decrement count. count reaching 0 returns to IDLE.
- Padding lanes are always the trailing lanes and are never emitted.

The gather and scatter paths are fully independent.

Reset (while rst high):
- All state and counters clear; handshakes are ignored.
- Outputs: s_byte_tready=1, m_blk_tvalid=0, m_blk_tdata=0, m_blk_tuser=0, s_blk_tready=1, m_byte_tvalid=0, m_byte_tdata=0.
- A partial block or in-flight bytes are dropped, with no output.

## Timing
- All outputs are registered or decoded from state only. There are no combinational paths from any input to any output.
- Full block: last byte accepted in cycle N -> m_blk_tvalid high in cycle N+1.
- Flush sampled in cycle N (idx>0) -> m_blk_tvalid high in cycle N+1.
- Timeout: last accept in cycle N, no accepts in N+1..N+TIMEOUT -> m_blk_tvalid high in cycle N+TIMEOUT+1.
- m_blk handshake in cycle M -> s_byte_tready high in M+1.
- Gather throughput is BLOCK_BYTES+1 cycles per block minimum.
- Block accepted in cycle K -> first m_byte_tvalid in K+1.
- Scatter with m_byte_tready held high: one byte per cycle.
- Last byte handshake in cycle L -> s_blk_tready high in L+1.
- AXI rules:
  - tvalid never drops without a handshake;
  - data/tuser are stable while tvalid && !tready.

## Test plan
- **Full block:** defaults; bytes 8'h00..8'h0B, back-to-back.
  -> m_blk_tdata = 96'h000102030405060708090A0B, tuser=0, tvalid one cycle after the last byte.
  -> With MSB_FIRST=0: 96'h0B0A09080706050403020100.
- **Timeout:** TIMEOUT=16; five bytes 8'hAA, then idle.
  -> m_blk_tdata = 96'hAAAAAAAAAA00000000000000, tuser=7, tvalid exactly 17 cycles after the last accept.
  -> 15 idle cycles followed by another byte produces no block.
- **Flush:** flush coincident with the 3rd byte (8'h11,22,33) -> tuser=9, block 96'h112233000000000000000000.
  -> Flush with idx==0 produces no output.
  -> Flush coincident with the 12th byte gives tuser=0.
- **Backpressure:** m_blk_tready low 20 cycles after tvalid.
  -> Data stable, s_byte_tready low throughout, resumes the cycle after the handshake.
- **Scatter:** block 96'h0102...0C with tuser=3 and random m_byte_tready.
  -> Exactly bytes 01..09 in order; s_blk_tready low until the cycle after byte 09.
  -> tuser=12 -> no bytes emitted.
- **Reset mid-operation:** rst for 1 cycle after 6 gathered bytes and mid-scatter.
  -> All outputs at their reset values.
  -> The next 12 bytes form a clean block with no stale lanes.

Source files
------------

// File: rtl/uart_block_bridge.sv
// Byte/block bridge: gathers UART bytes into cipher-width blocks (with pad count)
// and scatters returned blocks back into bytes, dropping trailing pad lanes.
module uart_block_bridge #(
    parameter int         BLOCK_BYTES = 12,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter int         TIMEOUT     = 0,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         PW          = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [7:0]                 s_byte_tdata,
    input  logic                       s_byte_tvalid,
    output logic                       s_byte_tready,
    output logic [8*BLOCK_BYTES-1:0]   m_blk_tdata,
    output logic                       m_blk_tvalid,
    input  logic                       m_blk_tready,
    output logic [PW-1:0]              m_blk_tuser,
    input  logic [8*BLOCK_BYTES-1:0]   s_blk_tdata,
    input  logic                       s_blk_tvalid,
    output logic                       s_blk_tready,
    input  logic [PW-1:0]              s_blk_tuser,
    output logic [7:0]                 m_byte_tdata,
    output logic                       m_byte_tvalid,
    input  logic                       m_byte_tready
);
    localparam int            BW       = 8 * BLOCK_BYTES;
    localparam int            TW       = $clog2(TIMEOUT + 2);
    localparam logic [PW-1:0] NBYTES   = PW'(BLOCK_BYTES);
    localparam logic [PW-1:0] LAST_IDX = PW'(BLOCK_BYTES - 1);

    typedef enum logic { G_FILL, G_HOLD } gstate_t;
    typedef enum logic { S_IDLE, S_SEND } sstate_t;

    // ---------------- gather path ----------------
    gstate_t         r_gstate, w_gstate_next;
    logic [PW-1:0]   r_idx, w_idx_next, w_idx_eff;
    logic [PW-1:0]   r_pad, w_pad_next;
    logic [TW-1:0]   r_idle, w_idle_next;
    logic            w_accept, w_close, w_expire;

    assign w_accept  = (r_gstate == G_FILL) && s_byte_tvalid;
    // Lane count after this cycle's byte lands; padding starts from here.
    assign w_idx_eff = r_idx + PW'(w_accept);
    assign w_expire  = (TIMEOUT != 0) && (r_gstate == G_FILL) && (r_idx != '0)
                       && !w_accept && (r_idle == TW'(TIMEOUT - 1));

    always_comb begin
        w_gstate_next = r_gstate;
        w_idx_next    = r_idx;
        w_pad_next    = r_pad;
        w_idle_next   = r_idle;
        w_close       = 1'b0;
        case (r_gstate)
            G_FILL: begin
                w_close = (w_accept && (r_idx == LAST_IDX))
                          || ((flush || w_expire) && (w_idx_eff != '0));
                if (w_close) begin
                    w_gstate_next = G_HOLD;
                    w_pad_next    = NBYTES - w_idx_eff;
                    w_idx_next    = w_idx_eff;
                    w_idle_next   = '0;
                end else if (w_accept) begin
                    w_idx_next  = w_idx_eff;
                    w_idle_next = '0;
                end else if (r_idx != '0) begin
                    w_idle_next = r_idle + TW'(1);
                end
            end
            G_HOLD: begin
                if (m_blk_tready) begin
                    w_gstate_next = G_FILL;
                    w_idx_next    = '0;
                    w_idle_next   = '0;
                end
            end
            default: w_gstate_next = G_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gstate <= G_FILL;
            r_idx    <= '0;
            r_pad    <= '0;
            r_idle   <= '0;
        end else begin
            r_gstate <= w_gstate_next;
            r_idx    <= w_idx_next;
            r_pad    <= w_pad_next;
            r_idle   <= w_idle_next;
        end
    end

    // One register per lane; lane gi is stream byte gi of the block.
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
        logic [7:0] r_lane;
        logic [7:0] w_lane_next;

        always_comb begin
            w_lane_next = r_lane;
            if (w_accept && (r_idx == PW'(gi)))
                w_lane_next = s_byte_tdata;
            else if (w_close && (PW'(gi) >= w_idx_eff))
                w_lane_next = PAD_BYTE;
        end

        always_ff @(posedge clk) begin
            if (rst) r_lane <= '0;
            else     r_lane <= w_lane_next;
        end

        if (MSB_FIRST) begin : g_msb
            assign m_blk_tdata[8*(BLOCK_BYTES-1-gi) +: 8] = r_lane;
        end else begin : g_lsb
            assign m_blk_tdata[8*gi +: 8] = r_lane;
        end
    end

    assign s_byte_tready = (r_gstate == G_FILL);
    assign m_blk_tvalid  = (r_gstate == G_HOLD);
    assign m_blk_tuser   = r_pad;

    // ---------------- scatter path ----------------
    sstate_t         r_sstate, w_sstate_next;
    logic [BW-1:0]   r_shift, w_shift_next;
    logic [PW-1:0]   r_count, w_count_next;

    always_comb begin
        w_sstate_next = r_sstate;
        w_shift_next  = r_shift;
        w_count_next  = r_count;
        case (r_sstate)
            S_IDLE: begin
                // A block that is all padding is consumed without output.
                if (s_blk_tvalid && (s_blk_tuser < NBYTES)) begin
                    w_sstate_next = S_SEND;
                    w_shift_next  = s_blk_tdata;
                    w_count_next  = NBYTES - s_blk_tuser;
                end
            end
            S_SEND: begin
                if (m_byte_tready) begin
                    w_shift_next = MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
                    w_count_next = r_count - PW'(1);
                    if (r_count == PW'(1)) w_sstate_next = S_IDLE;
                end
            end
            default: w_sstate_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sstate <= S_IDLE;
            r_shift  <= '0;
            r_count  <= '0;
        end else begin
            r_sstate <= w_sstate_next;
            r_shift  <= w_shift_next;
            r_count  <= w_count_next;
        end
    end

    assign s_blk_tready  = (r_sstate == S_IDLE);
    assign m_byte_tvalid = (r_sstate == S_SEND);
    assign m_byte_tdata  = MSB_FIRST ? r_shift[BW-1 -: 8] : r_shift[7:0];

endmodule
